pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ihit  input  1  instruction fetch completes this cycle.
REQ-005 dmem_req  input  1  instruction in EX/MEM is a load or store.
REQ-006 dhit  input  1  data access completes this cycle.
REQ-007 idex_memread  input  1  instruction in ID/EX is a load.
REQ-008 idex_rd  input  5  destination register of ID/EX instruction.
REQ-009 ifid_rs, ifid_rt  input  5 each  source registers of IF/ID instruction.
REQ-010 jump  input  1  jump resolved in ID this cycle.
REQ-011 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 halt_wb  input  1  halt instruction present in MEM/WB.
REQ-013 ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, exmem_flush, memwb_flush  output  1 each  pipeline register controls.
REQ-014 pc_en  output  1  PC register update enable.
REQ-015 halted  output  1  core halted, sticky.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-017 FSM states RUN, DWAIT, BUBBLE, HALTED; control outputs are combinational from state and inputs (no added latency); state, halted and counters are registered.
REQ-018 RUN -> DWAIT when dmem_req=1 and dhit=0; DWAIT -> RUN on first cycle dhit=1.
REQ-019 DWAIT, and RUN cycle with dmem_req=1 and dhit=0: ifid_freeze=idex_freeze=exmem_freeze=1, memwb_flush=1, pc_en=0, all other flushes 0.
REQ-020 Cycle dhit=1 after DWAIT: all freezes 0; pending jump/branch/load-use flushes apply in this same cycle per REQ-021..REQ-023.
REQ-021 Load-use hazard (RUN, no dmem stall): idex_memread=1, idex_rd!=0, idex_rd equals ifid_rs or ifid_rt -> ifid_freeze=1, idex_flush=1, pc_en=0; next state BUBBLE.
REQ-022 BUBBLE lasts exactly one cycle, behaves as RUN but load-use detection suppressed; -> RUN (or DWAIT per REQ-018).
REQ-023 branch_taken=1 (no dmem stall): ifid_flush=1, idex_flush=1, pc_en=1; overrides load-use (no freeze, no BUBBLE entry).
REQ-024 jump=1 without branch_taken (no dmem stall): ifid_flush=1, pc_en=1; idex_flush=0; load-use with jump: load-use wins, jump re-evaluated next cycle.
REQ-025 Otherwise RUN: all freezes/flushes 0, pc_en=ihit.
REQ-026 Priority: HALTED > dmem stall > branch_taken > load-use > jump > ihit.
REQ-027 halt_wb=1 and no dmem stall -> HALTED next cycle; halted=1 registered same edge.
REQ-028 HALTED: all freezes 1, all flushes 0, pc_en=0; exits only on reset.
REQ-029 stall_cnt increments each cycle pc_en=0 and state!=HALTED; flush_cnt increments each cycle ifid_flush=1; both saturate at 2^CNT_W-1, no wrap.
REQ-030 exmem_flush is 0 in all states (reserved for exception support).

Reset
REQ-031 nRST low: state=RUN, halted=0, stall_cnt=0, flush_cnt=0 asynchronously; control outputs reflect RUN with current inputs.
REQ-032 Reset asserted in DWAIT, BUBBLE or HALTED returns to RUN with no residual freeze or flush.

Verification
REQ-033 dmem_req=1, dhit=0 for 3 cycles then 1 -> 3 cycles of freezes=1, memwb_flush=1, pc_en=0; 4th cycle freezes 0; stall_cnt=3.
REQ-034 idex_memread=1, idex_rd=5, ifid_rt=5, ihit=1 -> ifid_freeze=1, idex_flush=1, pc_en=0 one cycle; next cycle same inputs -> no freeze (BUBBLE).
REQ-035 idex_rd=0 with matching ifid_rs=0 and idex_memread=1 -> no stall, pc_en=ihit.
REQ-036 branch_taken=1 and load-use same cycle -> ifid_flush=idex_flush=1, ifid_freeze=0, pc_en=1; flush_cnt +1.
REQ-037 branch_taken=1 during dmem stall -> freezes only; flush asserted in the dhit cycle.
REQ-038 halt_wb=1 -> halted=1 next cycle, all freezes 1, pc_en=0 until nRST pulse; counters preset to 2^CNT_W-2 saturate at max after 2 events.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: data-memory waits, load-use bubbles,
// branch/jump flushes and sticky halt, plus saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit_i,
    input  logic             dmem_req_i,
    input  logic             dhit_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    input  logic             halt_wb_i,
    output logic             ifid_freeze_o,
    output logic             ifid_flush_o,
    output logic             idex_freeze_o,
    output logic             idex_flush_o,
    output logic             exmem_freeze_o,
    output logic             exmem_flush_o,
    output logic             memwb_flush_o,
    output logic             pc_en_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        BUBBLE = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             dstall;
    logic             load_use;

    // State register, sticky halt flag and event counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and pipeline controls; priority halt > dmem > branch > load-use > jump > ihit
    always_comb begin
        state_d        = state_q;
        halted_d       = halted_q;
        ifid_freeze_o  = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_freeze_o  = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_freeze_o = 1'b0;
        exmem_flush_o  = 1'b0;
        memwb_flush_o  = 1'b0;
        pc_en_o        = 1'b0;

        // Once waiting, only dhit releases the stall
        if (state_q == DWAIT) begin
            dstall = !dhit_i;
        end else begin
            dstall = dmem_req_i && !dhit_i;
        end

        load_use = (state_q != BUBBLE) && idex_memread_i && (idex_rd_i != 5'd0) &&
                   ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

        if (state_q == HALTED) begin
            ifid_freeze_o  = 1'b1;
            idex_freeze_o  = 1'b1;
            exmem_freeze_o = 1'b1;
        end else if (dstall) begin
            ifid_freeze_o  = 1'b1;
            idex_freeze_o  = 1'b1;
            exmem_freeze_o = 1'b1;
            memwb_flush_o  = 1'b1;
            state_d        = DWAIT;
        end else begin
            state_d = RUN;
            if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
                pc_en_o      = 1'b1;
            end else if (load_use) begin
                ifid_freeze_o = 1'b1;
                idex_flush_o  = 1'b1;
                state_d       = BUBBLE;
            end else if (jump_i) begin
                ifid_flush_o = 1'b1;
                pc_en_o      = 1'b1;
            end else begin
                pc_en_o = ihit_i;
            end
            if (halt_wb_i) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en_o && (state_q != HALTED) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
